// File: rtl/serial_negate_unit.sv
// serial_negate_unit: digit-serial pass/invert/negate/abs with ovf, zf, sf flags
module serial_negate_unit #(
  parameter int WIDTH = 64,
  parameter int DIGIT = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] a,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             ovf,
  output logic             zf,
  output logic             sf
);
  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW = NDIG > 1 ? $clog2(NDIG) : 1;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t           r_state;
  logic [WIDTH-1:0] r_sh, r_acc;
  logic [CW-1:0]    r_cnt;
  logic             r_c, r_inv, r_ovf;
  logic [DIGIT:0]   w_sum;
  logic [WIDTH-1:0] w_nxt;
  logic             w_last, w_neg;
  always_comb begin
    w_sum  = {1'b0, r_inv ? ~r_sh[DIGIT-1:0] : r_sh[DIGIT-1:0]} + (DIGIT+1)'(r_c);
    w_nxt  = WIDTH'({w_sum[DIGIT-1:0], r_acc} >> DIGIT);
    w_last = r_cnt == CW'(NDIG - 1);
    w_neg  = mode == 2'b11 && a[WIDTH-1];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      r_cnt     <= '0;
      r_c       <= 1'b0;
      y         <= '0;
      ovf       <= 1'b0;
      zf        <= 1'b0;
      sf        <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid && in_ready) begin
            r_state  <= BUSY;
            in_ready <= 1'b0;
            r_sh     <= a;
            r_cnt    <= '0;
            r_inv    <= mode == 2'b11 ? w_neg : |mode;
            r_c      <= mode == 2'b10 || w_neg;
            r_ovf    <= mode[1] && a == {1'b1, {(WIDTH-1){1'b0}}};
          end else begin
            in_ready <= 1'b1;
          end
        end
        BUSY: begin
          r_sh  <= r_sh >> DIGIT;
          r_acc <= w_nxt;
          r_c   <= w_sum[DIGIT];
          r_cnt <= r_cnt + 1'b1;
          if (w_last) begin
            r_state   <= DONE;
            out_valid <= 1'b1;
            y         <= w_nxt;
            ovf       <= r_ovf;
            zf        <= w_nxt == '0;
            sf        <= w_nxt[WIDTH-1];
          end
        end
        DONE: begin
          if (out_ready) begin
            r_state   <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_negate_unit.sv
// tb_serial_negate_unit: directed table, handshake/reset corner cases and a width/digit sweep
module tb_serial_negate_unit;
  logic        clk = 1'b0;
  logic        rst, iv, or_r;
  logic [1:0]  md;
  logic [63:0] av;
  wire         ir, ov, ovf, zf, sf;
  wire  [63:0] y;
  logic [2:0]  s_iv;
  logic        s_or;
  logic [1:0]  s_mode;
  logic [63:0] s_a;
  wire  [2:0]  s_ir, s_ov, s_ovf, s_zf, s_sf;
  wire  [63:0] y0;
  wire  [15:0] y1;
  wire  [31:0] y2;
  int total = 0;
  int bad = 0;
  int lat;

  always #5 clk = ~clk;

  serial_negate_unit u_dut (
    .clk(clk), .rst(rst), .in_valid(iv), .in_ready(ir), .mode(md), .a(av),
    .out_valid(ov), .out_ready(or_r), .y(y), .ovf(ovf), .zf(zf), .sf(sf));
  serial_negate_unit #(.WIDTH(64), .DIGIT(64)) u_s0 (
    .clk(clk), .rst(rst), .in_valid(s_iv[0]), .in_ready(s_ir[0]), .mode(s_mode), .a(s_a),
    .out_valid(s_ov[0]), .out_ready(s_or), .y(y0), .ovf(s_ovf[0]), .zf(s_zf[0]), .sf(s_sf[0]));
  serial_negate_unit #(.WIDTH(16), .DIGIT(1)) u_s1 (
    .clk(clk), .rst(rst), .in_valid(s_iv[1]), .in_ready(s_ir[1]), .mode(s_mode), .a(s_a[15:0]),
    .out_valid(s_ov[1]), .out_ready(s_or), .y(y1), .ovf(s_ovf[1]), .zf(s_zf[1]), .sf(s_sf[1]));
  serial_negate_unit #(.WIDTH(32), .DIGIT(4)) u_s2 (
    .clk(clk), .rst(rst), .in_valid(s_iv[2]), .in_ready(s_ir[2]), .mode(s_mode), .a(s_a[31:0]),
    .out_valid(s_ov[2]), .out_ready(s_or), .y(y2), .ovf(s_ovf[2]), .zf(s_zf[2]), .sf(s_sf[2]));

  typedef struct {
    logic [1:0]  m;
    logic [63:0] a;
    logic [63:0] y;
    logic [2:0]  f;
  } vec_t;
  vec_t tv[10];

  task automatic chk(input string n, input logic [63:0] g, input logic [63:0] e);
    total++;
    if (g !== e) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", n, g, e);
    end
  endtask

  // behavioural reference: returns {ovf, zf, sf, y} for a w-bit operand
  function automatic logic [66:0] model(input logic [1:0] m, input logic [63:0] v, input int w);
    logic [63:0] msk, r;
    logic o;
    msk = w == 64 ? '1 : (64'd1 << w) - 64'd1;
    r = m == 2'd0 ? v : m == 2'd1 ? ~v : (m == 2'd2 || v[w-1]) ? -v : v;
    r = r & msk;
    o = m[1] && v == (64'd1 << (w - 1));
    return {o, r == 64'd0, r[w-1], r};
  endfunction

  task automatic op(input logic [1:0] m, input logic [63:0] v);
    int t = 0;
    while (!ir && t < 40) begin @(posedge clk); #1; t++; end
    chk("ready_wait", 64'(ir), 64'd1);
    md = m; av = v; iv = 1'b1;
    @(posedge clk); #1;
    iv = 1'b0; av = ~v; md = ~m;
    lat = 1;
    while (!ov && lat < 40) begin @(posedge clk); #1; lat++; end
  endtask

  task automatic sw(input int k, input int w, input int d);
    logic [63:0] msk, v, yk;
    logic [1:0]  m;
    logic [66:0] e;
    int t;
    msk = w == 64 ? '1 : (64'd1 << w) - 64'd1;
    for (int i = 0; i < 20; i++) begin
      v = {$urandom, $urandom} & msk;
      m = 2'($urandom_range(0, 3));
      if (i == 0) begin v = 64'd1 << (w - 1); m = 2'd3; end
      if (i == 1) begin v = 64'd1 << (w - 1); m = 2'd2; end
      if (i == 2) begin v = 64'd0; m = 2'd2; end
      t = 0;
      while (!s_ir[k] && t < 40) begin @(posedge clk); #1; t++; end
      chk("sw_ready", 64'(s_ir[k]), 64'd1);
      s_mode = m; s_a = v; s_iv[k] = 1'b1;
      @(posedge clk); #1;
      s_iv[k] = 1'b0; s_a = ~v;
      lat = 1;
      while (!s_ov[k] && lat < 100) begin @(posedge clk); #1; lat++; end
      chk("sw_latency", 64'(lat), 64'(w / d + 1));
      yk = k == 0 ? y0 : k == 1 ? {48'd0, y1} : {32'd0, y2};
      e = model(m, v, w);
      chk("sw_y", yk, e[63:0]);
      chk("sw_flags", 64'({s_ovf[k], s_zf[k], s_sf[k]}), 64'(e[66:64]));
      @(posedge clk); #1;
    end
  endtask

  initial begin
    logic seen;
    tv[0] = '{2'd2, 64'h0000000000000005, 64'hFFFFFFFFFFFFFFFB, 3'b001};
    tv[1] = '{2'd3, 64'hFFFFFFFFFFFFFFF6, 64'h000000000000000A, 3'b000};
    tv[2] = '{2'd3, 64'h8000000000000000, 64'h8000000000000000, 3'b101};
    tv[3] = '{2'd2, 64'h0000000000000000, 64'h0000000000000000, 3'b010};
    tv[4] = '{2'd1, 64'h00FF00FF00FF00FF, 64'hFF00FF00FF00FF00, 3'b001};
    tv[5] = '{2'd0, 64'h123456789ABCDEF0, 64'h123456789ABCDEF0, 3'b000};
    tv[6] = '{2'd2, 64'h8000000000000000, 64'h8000000000000000, 3'b101};
    tv[7] = '{2'd3, 64'h0000000000000007, 64'h0000000000000007, 3'b000};
    tv[8] = '{2'd1, 64'hFFFFFFFFFFFFFFFF, 64'h0000000000000000, 3'b010};
    tv[9] = '{2'd2, 64'h0000000000000001, 64'hFFFFFFFFFFFFFFFF, 3'b001};
    rst = 1'b1; iv = 1'b0; or_r = 1'b1; md = 2'd0; av = '0;
    s_iv = '0; s_or = 1'b1; s_mode = 2'd0; s_a = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 64'(ir), 64'd0);
    chk("rst_flags", 64'({ov, ovf, zf, sf}), 64'd0);
    chk("rst_y", y, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("ready_after_rst", 64'(ir), 64'd1);
    for (int i = 0; i < 10; i++) begin
      op(tv[i].m, tv[i].a);
      chk("latency", 64'(lat), 64'd9);
      chk("y", y, tv[i].y);
      chk("flags", 64'({ovf, zf, sf}), 64'(tv[i].f));
      @(posedge clk); #1;
      chk("post_handshake", 64'({ov, ir}), 64'b01);
    end
    or_r = 1'b0;
    op(2'd2, 64'h5);
    chk("bp_latency", 64'(lat), 64'd9);
    for (int i = 0; i < 5; i++) begin
      iv = 1'b1; av = {$urandom, $urandom}; md = 2'd0;
      @(posedge clk); #1;
      chk("bp_hold_ctl", 64'({ov, ir, ovf, zf, sf}), 64'b10001);
      chk("bp_hold_y", y, 64'hFFFFFFFFFFFFFFFB);
    end
    iv = 1'b0; or_r = 1'b1;
    @(posedge clk); #1;
    chk("bp_release", 64'({ov, ir}), 64'b01);
    seen = 1'b0;
    repeat (12) begin @(posedge clk); #1; seen |= ov; end
    chk("bp_pulses_ignored", 64'(seen), 64'd0);
    md = 2'd2; av = 64'h5; iv = 1'b1;
    @(posedge clk); #1;
    iv = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_ctl", 64'({ov, ir, ovf, zf, sf}), 64'd0);
    chk("abort_y", y, 64'd0);
    rst = 1'b0;
    seen = 1'b0;
    @(posedge clk); #1;
    chk("abort_ready", 64'(ir), 64'd1);
    repeat (14) begin @(posedge clk); #1; seen |= ov; end
    chk("abort_no_valid", 64'(seen), 64'd0);
    op(2'd2, 64'h10);
    chk("after_abort_lat", 64'(lat), 64'd9);
    chk("after_abort_y", y, 64'hFFFFFFFFFFFFFFF0);
    chk("after_abort_flags", 64'({ovf, zf, sf}), 64'b001);
    @(posedge clk); #1;
    sw(0, 64, 64);
    sw(1, 16, 1);
    sw(2, 32, 4);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
